// File: rtl/q2_io_if.sv
// rtl/q2_io_if.sv - q2 CPU bus bundle for the 0xFFF I/O responder
//
// Ports (as modports):
//   master : drives abus, dbus_in, wrm, rdm; observes dbus_out, dbus_oe
//   slave  : observes abus, dbus_in, wrm, rdm; drives dbus_out, dbus_oe
interface q2_io_if;
  logic [11:0] abus;
  logic [11:0] dbus_in;
  logic        wrm;
  logic        rdm;
  logic [11:0] dbus_out;
  logic        dbus_oe;

  modport master (output abus, dbus_in, wrm, rdm, input dbus_out, dbus_oe);
  modport slave  (input abus, dbus_in, wrm, rdm, output dbus_out, dbus_oe);
endinterface

// File: rtl/q2_io.sv
// rtl/q2_io.sv - q2 memory-mapped LCD/key responder at address 0xFFF
//
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   bus      : q2 CPU bus (slave modport): abus, dbus_in, wrm, rdm -> dbus_out, dbus_oe
//   keys_n   : raw asynchronous keys, 0 = pressed
//   lcd_rs   : LCD register select (1 = data, 0 = command)
//   lcd_e    : LCD enable strobe
//   lcd_data : LCD 8-bit data bus
module q2_io #(
  parameter int NKEYS      = 4,
  parameter int E_CYCLES   = 2,
  parameter int SHORT_WAIT = 50,
  parameter int CLEAR_WAIT = 2000,
  parameter int INIT_WAIT  = 20000,
  parameter int DEBOUNCE   = 1000
) (
  input  logic             clk,
  input  logic             rst,
  q2_io_if.slave           bus,
  input  logic [NKEYS-1:0] keys_n,
  output logic             lcd_rs,
  output logic             lcd_e,
  output logic [7:0]       lcd_data
);

  localparam int KW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  typedef enum logic [2:0] {RESET_WAIT, IDLE, SETUP, PULSE, SETTLE} state_t;

  logic              hit;
  logic              wrm_q;
  logic              accept;
  logic              cmd_valid;
  logic [8:0]        cmd;
  logic              push;
  logic              pop;
  logic              full;
  logic [8:0]        mem [4];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [2:0]        count;
  state_t            state;
  logic [31:0]       cnt;
  logic [31:0]       settle_len;
  logic [1:0]        init_idx;
  logic              in_init;
  logic [NKEYS-1:0]  sync1;
  logic [NKEYS-1:0]  sync2;
  logic [NKEYS-1:0]  key_lvl;
  logic [KW-1:0]     kcnt [NKEYS];
  logic [11:0]       rd_data;
  logic              unused_dbus_hi;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    init_rom = 8'h38;
      2'd1:    init_rom = 8'h0C;
      2'd2:    init_rom = 8'h06;
      default: init_rom = 8'h01;
    endcase
  endfunction

  assign hit            = (bus.abus == 12'hFFF);
  assign bus.dbus_oe    = bus.rdm & hit;
  assign unused_dbus_hi = &{1'b0, bus.dbus_in[11:9]};

  // Ready bit is taken from the registered count, so it lags a landing push by one edge.
  always_comb begin
    rd_data              = {~full, 11'h7FF};
    rd_data[NKEYS-1:0]   = key_lvl;
  end
  assign bus.dbus_out = rd_data;

  // Rising edge of wrm only: a held strobe enqueues once.
  assign accept = bus.wrm & ~wrm_q & hit;

  always_comb begin
    cmd_valid = 1'b0;
    cmd       = 9'h000;
    if (!bus.dbus_in[8]) begin
      cmd_valid = 1'b1;
      if (bus.dbus_in[7:0] < 8'h20 || bus.dbus_in[7:0] > 8'h7E)
        cmd = 9'h13F;
      else
        cmd = {1'b1, bus.dbus_in[7:0]};
    end else if (bus.dbus_in[7]) begin
      cmd_valid = 1'b1;
      cmd       = {2'b01, bus.dbus_in[6:0]};
    end else if (bus.dbus_in[0]) begin
      cmd_valid = 1'b1;
      cmd       = 9'h001;
    end
  end

  assign full = (count == 3'd4);
  assign push = accept & cmd_valid & ~full;
  assign pop  = (state == IDLE) && (count != 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrm_q <= 1'b0;
    else     wrm_q <= bus.wrm;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Clear (rs=0, 0x01) needs the long settle; everything else the short one.
  assign settle_len = (!lcd_rs && lcd_data == 8'h01) ? 32'(CLEAR_WAIT) : 32'(SHORT_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RESET_WAIT;
      cnt      <= 32'd0;
      init_idx <= 2'd0;
      in_init  <= 1'b1;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      case (state)
        RESET_WAIT: begin
          if (cnt == 32'(INIT_WAIT - 1)) begin
            cnt      <= 32'd0;
            init_idx <= 2'd0;
            lcd_rs   <= 1'b0;
            lcd_data <= init_rom(2'd0);
            state    <= SETUP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        IDLE: begin
          if (pop) begin
            {lcd_rs, lcd_data} <= mem[rd_ptr];
            state              <= SETUP;
          end
        end
        SETUP: begin
          lcd_e <= 1'b1;
          cnt   <= 32'd0;
          state <= PULSE;
        end
        PULSE: begin
          if (cnt == 32'(E_CYCLES - 1)) begin
            lcd_e <= 1'b0;
            cnt   <= 32'd0;
            state <= SETTLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        SETTLE: begin
          if (cnt == settle_len - 32'd1) begin
            cnt <= 32'd0;
            // Init entries chain straight into SETUP so they go out back to back.
            if (in_init && init_idx != 2'd3) begin
              init_idx <= init_idx + 2'd1;
              lcd_data <= init_rom(init_idx + 2'd1);
              state    <= SETUP;
            end else begin
              in_init <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= RESET_WAIT;
      endcase
    end
  end

  // Per-key debounce: counter runs only while the synced level disagrees with the accepted one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '1;
      sync2   <= '1;
      key_lvl <= '1;
      for (int i = 0; i < NKEYS; i++) kcnt[i] <= '0;
    end else begin
      sync1 <= keys_n;
      sync2 <= sync1;
      for (int i = 0; i < NKEYS; i++) begin
        if (sync2[i] != key_lvl[i]) begin
          if (kcnt[i] == KW'(DEBOUNCE - 1)) begin
            key_lvl[i] <= sync2[i];
            kcnt[i]    <= '0;
          end else begin
            kcnt[i] <= kcnt[i] + KW'(1);
          end
        end else begin
          kcnt[i] <= '0;
        end
      end
    end
  end

endmodule
